// File: rtl/fpu_order_gate.sv
// Issue-ordering gate in front of the FPU/DIV demux: holds unit-type switches until all results return,
// caps outstanding ops, and registers the response path. Optional macro FPU_ORDER_GATE_PERF_EN adds stall_cnt_o.
module fpu_order_gate #(
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned FP_TYPE_WIDTH   = 5,
    parameter int unsigned NB_ARGS         = 3,
    parameter int unsigned OPCODE_WIDTH    = 6,
    parameter int unsigned DSFLAGS_CPU     = 15,
    parameter int unsigned USFLAGS_CPU     = 5,
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter int unsigned APU_ID          = 1,
    parameter int unsigned FPNEW_ID        = 0
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            core_slave_req_i,
    output logic                            core_slave_gnt_o,
    input  logic [FP_TYPE_WIDTH-1:0]        core_slave_type_i,
    input  logic [NB_ARGS*DATA_WIDTH-1:0]   core_slave_operands_i,
    input  logic [OPCODE_WIDTH-1:0]         core_slave_op_i,
    input  logic [DSFLAGS_CPU-1:0]          core_slave_flags_i,
    input  logic                            core_slave_rready_i,
    output logic                            core_slave_rvalid_o,
    output logic [DATA_WIDTH-1:0]           core_slave_rdata_o,
    output logic [USFLAGS_CPU-1:0]          core_slave_rflags_o,
    output logic                            fpu_req_o,
    input  logic                            fpu_gnt_i,
    output logic [FP_TYPE_WIDTH-1:0]        fpu_type_o,
    output logic [NB_ARGS*DATA_WIDTH-1:0]   fpu_operands_o,
    output logic [OPCODE_WIDTH-1:0]         fpu_op_o,
    output logic [DSFLAGS_CPU-1:0]          fpu_flags_o,
    output logic                            fpu_rready_o,
    input  logic                            fpu_rvalid_i,
    input  logic [DATA_WIDTH-1:0]           fpu_rdata_i,
    input  logic [USFLAGS_CPU-1:0]          fpu_rflags_i
`ifdef FPU_ORDER_GATE_PERF_EN
    ,
    output logic [31:0]                     stall_cnt_o
`endif
);

    localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);

    // The ordering scheme only works if the two shared units have distinct type codes.
    if (APU_ID == FPNEW_ID || MAX_OUTSTANDING < 1) begin : g_bad_cfg
        $error("fpu_order_gate: APU_ID must differ from FPNEW_ID and MAX_OUTSTANDING must be >= 1");
    end

    logic [CNT_W-1:0]         cnt_q;
    logic [FP_TYPE_WIDTH-1:0] last_type_q;
    logic                     valid_q;
    logic [DATA_WIDTH-1:0]    data_q;
    logic [USFLAGS_CPU-1:0]   flags_q;
    logic                     allow;
    logic                     accept;
    logic                     retire;

    // Issue only into an empty pipe or behind same-type work with room left.
    assign allow = (cnt_q == '0)
                 | ((core_slave_type_i == last_type_q) & (cnt_q < CNT_W'(MAX_OUTSTANDING)));

    assign fpu_req_o        = core_slave_req_i & allow;
    assign core_slave_gnt_o = fpu_gnt_i & allow;
    assign accept           = fpu_req_o & fpu_gnt_i;
    assign retire           = valid_q & core_slave_rready_i;

    assign fpu_type_o     = core_slave_type_i;
    assign fpu_operands_o = core_slave_operands_i;
    assign fpu_op_o       = core_slave_op_i;
    assign fpu_flags_o    = core_slave_flags_i;

    assign fpu_rready_o        = ~valid_q | core_slave_rready_i;
    assign core_slave_rvalid_o = valid_q;
    assign core_slave_rdata_o  = data_q;
    assign core_slave_rflags_o = flags_q;

    // Outstanding counter; a retire at zero is a pre-reset straggler and must not wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q       <= '0;
            last_type_q <= FP_TYPE_WIDTH'(FPNEW_ID);
        end else begin
            if (accept) begin
                last_type_q <= core_slave_type_i;
            end
            if (accept & ~retire) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end else if (retire & ~accept & (cnt_q != '0)) begin
                cnt_q <= cnt_q - CNT_W'(1);
            end
        end
    end

    // Single-entry response register, full throughput when the core is ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            flags_q <= '0;
        end else if (fpu_rvalid_i & fpu_rready_o) begin
            valid_q <= 1'b1;
            data_q  <= fpu_rdata_i;
            flags_q <= fpu_rflags_i;
        end else if (retire) begin
            valid_q <= 1'b0;
        end
    end

`ifdef FPU_ORDER_GATE_PERF_EN
    logic [31:0] stall_cnt_q;

    // Saturating count of cycles a request is held back by the gate.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else if (core_slave_req_i & ~allow & ~(&stall_cnt_q)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fpu_order_gate.sv
// Self-checking bench for fpu_order_gate: per-cycle vector table, reset/stale-result sequence,
// optional stall counter check, and a randomized scoreboard acting as the demux.
module tb_fpu_order_gate;

    logic         clk;
    logic         rst;
    logic         req;
    logic         gnt_o;
    logic [4:0]   typ;
    logic [95:0]  operands;
    logic [5:0]   op;
    logic [14:0]  flags;
    logic         rready;
    logic         rvalid_o;
    logic [31:0]  rdata_o;
    logic [4:0]   rflags_o;
    logic         fpu_req;
    logic         fpu_gnt;
    logic [4:0]   fpu_type;
    logic [95:0]  fpu_operands;
    logic [5:0]   fpu_op;
    logic [14:0]  fpu_flags;
    logic         fpu_rready;
    logic         fpu_rvalid;
    logic [31:0]  fpu_rdata;
    logic [4:0]   fpu_rflags;
`ifdef FPU_ORDER_GATE_PERF_EN
    logic [31:0]  stall_cnt;
`endif

    int n_cmp = 0;
    int n_err = 0;

    fpu_order_gate dut (
        .clk                   (clk),
        .rst                   (rst),
        .core_slave_req_i      (req),
        .core_slave_gnt_o      (gnt_o),
        .core_slave_type_i     (typ),
        .core_slave_operands_i (operands),
        .core_slave_op_i       (op),
        .core_slave_flags_i    (flags),
        .core_slave_rready_i   (rready),
        .core_slave_rvalid_o   (rvalid_o),
        .core_slave_rdata_o    (rdata_o),
        .core_slave_rflags_o   (rflags_o),
        .fpu_req_o             (fpu_req),
        .fpu_gnt_i             (fpu_gnt),
        .fpu_type_o            (fpu_type),
        .fpu_operands_o        (fpu_operands),
        .fpu_op_o              (fpu_op),
        .fpu_flags_o           (fpu_flags),
        .fpu_rready_o          (fpu_rready),
        .fpu_rvalid_i          (fpu_rvalid),
        .fpu_rdata_i           (fpu_rdata),
        .fpu_rflags_i          (fpu_rflags)
`ifdef FPU_ORDER_GATE_PERF_EN
        ,
        .stall_cnt_o           (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h required %h", name, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        req;
        logic [4:0]  typ;
        logic        gnt;
        logic        rv;
        logic [31:0] rd;
        logic        rr;
        logic        ereq;
        logic        egnt;
        logic        erdy;
        logic        eval;
        logic [31:0] edata;
    } vec_t;

    function automatic vec_t mk(input logic rq, input logic [4:0] t, input logic g, input logic rv,
                                input logic [31:0] rd, input logic rr, input logic ereq,
                                input logic egnt, input logic erdy, input logic ev,
                                input logic [31:0] ed);
        vec_t v;
        v.req = rq; v.typ = t; v.gnt = g; v.rv = rv; v.rd = rd; v.rr = rr;
        v.ereq = ereq; v.egnt = egnt; v.erdy = erdy; v.eval = ev; v.edata = ed;
        return v;
    endfunction

    localparam logic [31:0] A1 = 32'hA000_0011, A2 = 32'hA000_0022, A3 = 32'hA000_0033;
    localparam logic [31:0] B1 = 32'hB000_0041, B2 = 32'hB000_0052;
    localparam logic [31:0] C1 = 32'hC000_0063;
    localparam logic [31:0] D1 = 32'hD000_0074, D2 = 32'hD000_0085;
    localparam logic [31:0] D3 = 32'hD000_0096, D4 = 32'hD000_00A7;
    localparam logic [31:0] E1 = 32'hE000_00B8, F1 = 32'hF000_00C9;

    vec_t tbl [30];

    // scoreboard state
    logic [36:0] pend [$];
    logic [36:0] expq [$];
    logic [36:0] item;
    int          m_cnt;
    logic [4:0]  m_last;
    logic        m_valid;
    logic        m_allow, acc, ld, ret, hold;

    initial begin
        // in-order FPNEW burst, type switch, cap at 4, backpressure, then two in flight
        for (int i = 0; i < 3; i++) tbl[i] = mk(1, 0, 1, 0, 0, 1, 1, 1, 1, 0, 0);
        tbl[3]  = mk(0, 0, 0, 1, A1, 1, 0, 0, 1, 0, 0);
        tbl[4]  = mk(0, 0, 0, 1, A2, 1, 0, 0, 1, 1, A1);
        tbl[5]  = mk(0, 0, 0, 1, A3, 1, 0, 0, 1, 1, A2);
        tbl[6]  = mk(0, 0, 0, 0, 0,  1, 0, 0, 1, 1, A3);
        tbl[7]  = mk(1, 1, 0, 0, 0,  1, 1, 0, 1, 0, 0);
        tbl[8]  = mk(1, 0, 1, 0, 0,  1, 1, 1, 1, 0, 0);
        tbl[9]  = mk(1, 1, 1, 1, B1, 1, 0, 0, 1, 0, 0);
        tbl[10] = mk(1, 1, 1, 0, 0,  1, 0, 0, 1, 1, B1);
        tbl[11] = mk(1, 1, 1, 0, 0,  1, 1, 1, 1, 0, 0);
        tbl[12] = mk(0, 1, 0, 1, B2, 1, 0, 0, 1, 0, 0);
        tbl[13] = mk(0, 1, 0, 0, 0,  1, 0, 0, 1, 1, B2);
        for (int i = 14; i < 18; i++) tbl[i] = mk(1, 1, 1, 0, 0, 1, 1, 1, 1, 0, 0);
        tbl[18] = mk(1, 1, 1, 1, C1, 1, 0, 0, 1, 0, 0);
        tbl[19] = mk(1, 1, 1, 0, 0,  1, 0, 0, 1, 1, C1);
        tbl[20] = mk(1, 1, 1, 0, 0,  1, 1, 1, 1, 0, 0);
        tbl[21] = mk(0, 1, 0, 1, D1, 0, 0, 0, 1, 0, 0);
        tbl[22] = mk(0, 1, 0, 1, D2, 0, 0, 0, 0, 1, D1);
        tbl[23] = mk(0, 1, 0, 1, D2, 0, 0, 0, 0, 1, D1);
        tbl[24] = mk(0, 1, 0, 1, D2, 1, 0, 0, 1, 1, D1);
        tbl[25] = mk(0, 1, 0, 1, D3, 1, 0, 0, 1, 1, D2);
        tbl[26] = mk(0, 1, 0, 1, D4, 1, 0, 0, 1, 1, D3);
        tbl[27] = mk(0, 1, 0, 0, 0,  1, 0, 0, 1, 1, D4);
        tbl[28] = mk(1, 0, 1, 0, 0,  1, 1, 1, 1, 0, 0);
        tbl[29] = mk(1, 0, 1, 1, E1, 0, 1, 1, 1, 0, 0);

        rst = 1'b1; req = 1'b1; typ = 5'd1; operands = '0; op = '0; flags = '0;
        rready = 1'b0; fpu_gnt = 1'b1; fpu_rvalid = 1'b0; fpu_rdata = '0; fpu_rflags = '0;
        #12;
        check("reset_outputs", 128'({fpu_req, gnt_o, fpu_rready, rvalid_o, rflags_o, rdata_o}),
              128'({1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 32'd0}));
        next_cycle();
        rst = 1'b0; req = 1'b0;

        for (int i = 0; i < 30; i++) begin
            req = tbl[i].req; typ = tbl[i].typ; fpu_gnt = tbl[i].gnt;
            fpu_rvalid = tbl[i].rv; fpu_rdata = tbl[i].rd; fpu_rflags = tbl[i].rd[4:0];
            rready = tbl[i].rr;
            #1;
            check($sformatf("row%0d", i),
                  128'({fpu_req, gnt_o, fpu_rready, rvalid_o,
                        tbl[i].eval ? rflags_o : 5'd0, tbl[i].eval ? rdata_o : 32'd0}),
                  128'({tbl[i].ereq, tbl[i].egnt, tbl[i].erdy, tbl[i].eval,
                        tbl[i].eval ? tbl[i].edata[4:0] : 5'd0, tbl[i].edata}));
            next_cycle();
        end

        // reset with two outstanding and a held result, then a stale result afterwards
        req = 1'b0; fpu_rvalid = 1'b0; rready = 1'b0; fpu_gnt = 1'b0;
        #1;
        check("pre_reset_hold", 128'({rvalid_o, rdata_o}), 128'({1'b1, E1}));
        rst = 1'b1;
        #1;
        check("reset_immediate", 128'({rvalid_o, fpu_rready}), 128'({1'b0, 1'b1}));
        next_cycle();
        rst = 1'b0;
        req = 1'b1; typ = 5'd1; fpu_gnt = 1'b0;
        fpu_rvalid = 1'b1; fpu_rdata = F1; fpu_rflags = F1[4:0]; rready = 1'b1;
        #1;
        check("post_reset_switch", 128'(fpu_req), 128'(1'b1));
        next_cycle();
        fpu_rvalid = 1'b0;
        #1;
        check("stale_delivered", 128'({rvalid_o, rflags_o, rdata_o}), 128'({1'b1, F1[4:0], F1}));
        next_cycle();
        #1;
        check("stale_no_underflow", 128'({fpu_req, rvalid_o}), 128'({1'b1, 1'b0}));

`ifdef FPU_ORDER_GATE_PERF_EN
        rst = 1'b1; req = 1'b0; #1; rst = 1'b0;
        check("stall_reset", 128'(stall_cnt), 128'(32'd0));
        next_cycle();
        req = 1'b1; typ = 5'd0; fpu_gnt = 1'b1;
        next_cycle();
        typ = 5'd1;
        for (int i = 0; i < 7; i++) next_cycle();
        req = 1'b0;
        #1;
        check("stall_cnt7", 128'(stall_cnt), 128'(32'd7));
`endif

        // randomized traffic; the bench plays the demux and keeps an independent model
        rst = 1'b1; req = 1'b0; fpu_rvalid = 1'b0; #1; rst = 1'b0;
        next_cycle();
        m_cnt = 0; m_last = 5'd0; m_valid = 1'b0; hold = 1'b0;
        for (int c = 0; c < 600; c++) begin
            if (c >= 400 && pend.size() == 0 && expq.size() == 0 && !m_valid && !hold) break;
            if (!hold) begin
                req      = (c < 400) ? 1'($urandom_range(0, 1)) : 1'b0;
                typ      = 5'($urandom_range(0, 1));
                operands = {$urandom, $urandom, $urandom};
                op       = 6'($urandom);
                flags    = 15'($urandom);
            end
            fpu_gnt = ($urandom_range(0, 3) != 0);
            rready  = (c >= 400) ? 1'b1 : ($urandom_range(0, 3) != 0);
            fpu_rvalid = (pend.size() > 0) && ((c >= 400) || ($urandom_range(0, 1) == 1));
            item = (pend.size() > 0) ? pend[0] : 37'd0;
            fpu_rdata  = item[31:0];
            fpu_rflags = item[36:32];
            #1;
            m_allow = (m_cnt == 0) || ((typ == m_last) && (m_cnt < 4));
            check($sformatf("sb_ctrl c%0d", c),
                  128'({fpu_req, gnt_o, fpu_rready, rvalid_o}),
                  128'({req & m_allow, fpu_gnt & m_allow, ~m_valid | rready, m_valid}));
            if (c % 50 == 0)
                check($sformatf("passthru c%0d", c),
                      128'({fpu_type, fpu_operands, fpu_op, fpu_flags}),
                      128'({typ, operands, op, flags}));
            acc = req & m_allow & fpu_gnt;
            ld  = fpu_rvalid & (~m_valid | rready);
            ret = m_valid & rready;
            if (ret) begin
                if (expq.size() == 0) begin
                    check($sformatf("sb_underflow c%0d", c), 128'(1), 128'(0));
                end else begin
                    item = expq.pop_front();
                    check($sformatf("sb_data c%0d", c), 128'({rflags_o, rdata_o}), 128'(item));
                end
            end
            if (ld) expq.push_back(pend.pop_front());
            if (acc) pend.push_back({op[4:0], operands[31:0] ^ operands[63:32]});
            if (acc && !ret) m_cnt++;
            else if (ret && !acc && m_cnt > 0) m_cnt--;
            if (acc) m_last = typ;
            m_valid = ld ? 1'b1 : (ret ? 1'b0 : m_valid);
            hold = req & ~acc;
            next_cycle();
        end
        check("sb_drained", 128'({32'(pend.size()), 32'(expq.size()), m_valid}), 128'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
